// File: rtl/exu_stage_pkg.sv
// Purpose: shared encodings for the execute stage (ALU opcodes, instruction kind, branch condition).
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package exu_stage_pkg;

   // ALU opcode encoding as produced by decode; unlisted codes pass the right operand.
   typedef enum logic [3:0] {
      ALU_ADD  = 4'b0000,
      ALU_SUB  = 4'b0001,
      ALU_SLL  = 4'b0010,
      ALU_SLT  = 4'b0100,
      ALU_SLTU = 4'b0110,
      ALU_XOR  = 4'b1000,
      ALU_SRL  = 4'b1010,
      ALU_SRA  = 4'b1011,
      ALU_OR   = 4'b1100,
      ALU_AND  = 4'b1110
   } alu_op_e;

   typedef enum logic [1:0] {
      KIND_ALU    = 2'd0,
      KIND_BRANCH = 2'd1,
      KIND_JAL    = 2'd2,
      KIND_JALR   = 2'd3
   } kind_e;

   // RV32I branch condition evaluated on the ALU outcome: BEQ/BNE look at the
   // zero flag of a SUB, the ordered compares look at bit 0 of SLT/SLTU.
   function automatic logic branch_taken(input logic [2:0] funct3,
                                         input logic       zero_flag,
                                         input logic       res_lsb);
      logic taken;
      taken = 1'b0;
      case (funct3)
         3'b000:         taken = zero_flag;
         3'b001:         taken = ~zero_flag;
         3'b100, 3'b110: taken = res_lsb;
         3'b101, 3'b111: taken = ~res_lsb;
         default:        taken = 1'b0;
      endcase
      return taken;
   endfunction

endpackage

// File: rtl/exu_stage_alu.sv
// Purpose: combinational integer ALU with zero flag.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output follows inputs.
// Ports: op (opcode), a/b (operands), result, zero (result == 0).
module exu_stage_alu
   import exu_stage_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] result,
   output logic             zero
);

   localparam int SHW = $clog2(WIDTH);

   logic [SHW-1:0] shamt;

   assign shamt = b[SHW-1:0];

   always_comb begin
      result = b;
      case (alu_op_e'(op))
         ALU_ADD:  result = a + b;
         ALU_SUB:  result = a - b;
         ALU_AND:  result = a & b;
         ALU_OR:   result = a | b;
         ALU_XOR:  result = a ^ b;
         ALU_SLL:  result = a << shamt;
         ALU_SRL:  result = a >> shamt;
         ALU_SRA:  result = $signed(a) >>> shamt;
         ALU_SLT:  result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
         ALU_SLTU: result = {{(WIDTH-1){1'b0}}, (a < b)};
         default:  result = b;
      endcase
   end

   assign zero = (result == '0);

endmodule

// File: rtl/exu_stage.sv
// Purpose: single-entry execute stage: ALU, branch/jump resolution, registered result and redirect.
// Latency: 1 cycle in-to-out; redirect pulses the cycle after the accepting edge.
// Backpressure: in_ready = empty or out_ready (full entry can be replaced in the same edge); flush drops both entries.
// Ports: in_* decode handshake and operands; out_* result handshake to mem/wb;
//        redirect_valid/redirect_pc fetch redirect; flush kills held and offered instruction.
module exu_stage
   import exu_stage_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_pc,
   input  logic [WIDTH-1:0] in_rs1,
   input  logic [WIDTH-1:0] in_rs2,
   input  logic [WIDTH-1:0] in_imm,
   input  logic [3:0]       in_alu_op,
   input  logic             in_src1_pc,
   input  logic             in_src2_imm,
   input  logic [1:0]       in_kind,
   input  logic [2:0]       in_funct3,
   input  logic [4:0]       in_rd,
   input  logic             in_wen,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_result,
   output logic [4:0]       out_rd,
   output logic             out_wen,
   output logic             redirect_valid,
   output logic [WIDTH-1:0] redirect_pc
);

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } state_e;

   state_e state_q, state_d;

   logic             accept;
   kind_e            kind;
   logic [WIDTH-1:0] alu_a, alu_b, alu_res;
   logic             alu_zero;
   logic [WIDTH-1:0] link_pc;
   logic [WIDTH-1:0] tgt_base, tgt_sum, target;
   logic             take_redirect;
   logic [WIDTH-1:0] result_d;
   logic             wen_d;

   assign kind  = kind_e'(in_kind);
   assign alu_a = in_src1_pc  ? in_pc  : in_rs1;
   assign alu_b = in_src2_imm ? in_imm : in_rs2;

   exu_stage_alu #(.WIDTH(WIDTH)) u_alu (
      .op     (in_alu_op),
      .a      (alu_a),
      .b      (alu_b),
      .result (alu_res),
      .zero   (alu_zero)
   );

   // Link address and branch target have their own adders so the ALU stays
   // free for the branch compare.
   assign link_pc  = in_pc + {{(WIDTH-3){1'b0}}, 3'b100};
   assign tgt_base = (kind == KIND_JALR) ? in_rs1 : in_pc;
   assign tgt_sum  = tgt_base + in_imm;
   assign target   = (kind == KIND_JALR) ? {tgt_sum[WIDTH-1:1], 1'b0} : tgt_sum;

   always_comb begin
      take_redirect = 1'b0;
      result_d      = alu_res;
      wen_d         = in_wen;
      case (kind)
         KIND_BRANCH: begin
            take_redirect = branch_taken(in_funct3, alu_zero, alu_res[0]);
            wen_d         = 1'b0;
         end
         KIND_JAL, KIND_JALR: begin
            take_redirect = 1'b1;
            result_d      = link_pc;
         end
         default: begin
            take_redirect = 1'b0;
         end
      endcase
   end

   // Handshake and next state. Flush wins over everything except reset.
   always_comb begin
      state_d   = state_q;
      in_ready  = (state_q == ST_EMPTY) || out_ready;
      out_valid = (state_q == ST_FULL);
      accept    = in_valid && in_ready && !flush;
      if (flush) begin
         state_d = ST_EMPTY;
      end else if (accept) begin
         state_d = ST_FULL;
      end else if ((state_q == ST_FULL) && out_ready) begin
         state_d = ST_EMPTY;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   // Payload only moves on accept, so it is stable while stalled.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_result  <= '0;
         out_rd      <= '0;
         out_wen     <= 1'b0;
         redirect_pc <= '0;
      end else if (accept) begin
         out_result  <= result_d;
         out_rd      <= in_rd;
         out_wen     <= wen_d;
         redirect_pc <= target;
      end
   end

   // One-cycle pulse: recomputed every edge, so a stalled entry never re-fires
   // and a flush edge clears it.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         redirect_valid <= 1'b0;
      end else begin
         redirect_valid <= accept && take_redirect;
      end
   end

endmodule

// File: tb/tb_exu_stage.sv
module tb_exu_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_pc, in_rs1, in_rs2, in_imm;
   logic [3:0]  in_alu_op;
   logic        in_src1_pc, in_src2_imm;
   logic [1:0]  in_kind;
   logic [2:0]  in_funct3;
   logic [4:0]  in_rd;
   logic        in_wen;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_result;
   logic [4:0]  out_rd;
   logic        out_wen;
   logic        redirect_valid;
   logic [31:0] redirect_pc;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   exu_stage #(.WIDTH(32)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .in_pc          (in_pc),
      .in_rs1         (in_rs1),
      .in_rs2         (in_rs2),
      .in_imm         (in_imm),
      .in_alu_op      (in_alu_op),
      .in_src1_pc     (in_src1_pc),
      .in_src2_imm    (in_src2_imm),
      .in_kind        (in_kind),
      .in_funct3      (in_funct3),
      .in_rd          (in_rd),
      .in_wen         (in_wen),
      .flush          (flush),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_result     (out_result),
      .out_rd         (out_rd),
      .out_wen        (out_wen),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc)
   );

   // ---------------- reference model (instruction semantics) ----------------
   function automatic logic [31:0] m_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [31:0] r;
      case (op)
         4'd0:    r = a + b;
         4'd1:    r = a - b;
         4'd14:   r = a & b;
         4'd12:   r = a | b;
         4'd8:    r = a ^ b;
         4'd2:    r = a << b[4:0];
         4'd10:   r = a >> b[4:0];
         4'd11:   r = $signed(a) >>> b[4:0];
         4'd4:    r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         4'd6:    r = (a < b) ? 32'd1 : 32'd0;
         default: r = b;
      endcase
      return r;
   endfunction

   function automatic logic m_cond(input logic [2:0] f3, input logic [31:0] r);
      if (f3 == 3'd0) return r == 0;
      if (f3 == 3'd1) return r != 0;
      if (f3 == 3'd4 || f3 == 3'd6) return r[0];
      if (f3 == 3'd5 || f3 == 3'd7) return !r[0];
      return 1'b0;
   endfunction

   task automatic set_instr(input logic [31:0] pc, input logic [31:0] rs1, input logic [31:0] rs2,
                            input logic [31:0] imm, input logic [3:0] op, input logic s1pc,
                            input logic s2imm, input logic [1:0] kind, input logic [2:0] f3,
                            input logic [4:0] rd, input logic wen);
      in_valid = 1'b1; in_pc = pc; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
      in_alu_op = op; in_src1_pc = s1pc; in_src2_imm = s2imm; in_kind = kind;
      in_funct3 = f3; in_rd = rd; in_wen = wen;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // ---------------- directed scenarios ----------------
   task automatic test_reset();
      rst_n = 1'b0; flush = 1'b1; out_ready = 1'b1;
      set_instr(32'h40, 32'h1, 32'h2, 32'h3, 4'd0, 1'b0, 1'b0, 2'd2, 3'd0, 5'd9, 1'b1);
      tick(); flush = 1'b0; tick();
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      n_cmp++; if (redirect_valid !== 1'b0) begin n_err++; $display("FAIL reset_redirect_valid: got %b want 0", redirect_valid); end
      n_cmp++; if (out_wen !== 1'b0 || out_rd !== 5'd0) begin n_err++; $display("FAIL reset_wen_rd: got %b/%0d want 0/0", out_wen, out_rd); end
      n_cmp++; if (out_result !== 32'd0 || redirect_pc !== 32'd0) begin n_err++; $display("FAIL reset_data: got %h/%h want 0/0", out_result, redirect_pc); end
      in_valid = 1'b0; rst_n = 1'b1; #1;
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
   endtask

   task automatic test_alu_add();
      out_ready = 1'b1;
      set_instr(32'h0, 32'd5, 32'd99, 32'd7, 4'd0, 1'b0, 1'b1, 2'd0, 3'd0, 5'd3, 1'b1);
      tick(); in_valid = 1'b0;
      n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL add_valid: got %b want 1", out_valid); end
      n_cmp++; if (out_result !== 32'd12) begin n_err++; $display("FAIL add_result: got %0d want 12", out_result); end
      n_cmp++; if (out_wen !== 1'b1 || out_rd !== 5'd3) begin n_err++; $display("FAIL add_wen_rd: got %b/%0d want 1/3", out_wen, out_rd); end
      n_cmp++; if (redirect_valid !== 1'b0) begin n_err++; $display("FAIL add_no_redirect: got %b want 0", redirect_valid); end
      tick();
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL add_drain: got %b want 0", out_valid); end
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0;
      set_instr(32'h0, 32'd10, 32'd20, 32'd0, 4'd0, 1'b0, 1'b0, 2'd0, 3'd0, 5'd4, 1'b1);
      tick();
      set_instr(32'h0, 32'd1, 32'd2, 32'd0, 4'd0, 1'b0, 1'b0, 2'd0, 3'd0, 5'd6, 1'b1);
      for (int i = 0; i < 3; i++) begin
         #1;
         n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready[%0d]: got %b want 0", i, in_ready); end
         n_cmp++; if (out_valid !== 1'b1 || out_result !== 32'd30 || out_rd !== 5'd4) begin
            n_err++; $display("FAIL bp_stable[%0d]: got v=%b r=%0d rd=%0d want v=1 r=30 rd=4", i, out_valid, out_result, out_rd);
         end
         tick();
      end
      out_ready = 1'b1; #1;
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_release_ready: got %b want 1", in_ready); end
      tick(); in_valid = 1'b0;
      n_cmp++; if (out_valid !== 1'b1 || out_result !== 32'd3 || out_rd !== 5'd6) begin
         n_err++; $display("FAIL bp_replace: got v=%b r=%0d rd=%0d want v=1 r=3 rd=6", out_valid, out_result, out_rd);
      end
      tick();
   endtask

   task automatic test_beq();
      out_ready = 1'b1;
      set_instr(32'h100, 32'd9, 32'd9, 32'h20, 4'd1, 1'b0, 1'b0, 2'd1, 3'b000, 5'd5, 1'b1);
      tick(); in_valid = 1'b0;
      n_cmp++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h120) begin
         n_err++; $display("FAIL beq_redirect: got %b/%h want 1/120", redirect_valid, redirect_pc);
      end
      n_cmp++; if (out_wen !== 1'b0) begin n_err++; $display("FAIL beq_wen: got %b want 0", out_wen); end
      tick();
      n_cmp++; if (redirect_valid !== 1'b0) begin n_err++; $display("FAIL beq_pulse: got %b want 0", redirect_valid); end
   endtask

   task automatic test_jalr();
      out_ready = 1'b1;
      set_instr(32'h80, 32'h203, 32'h0, 32'h4, 4'd0, 1'b0, 1'b1, 2'd3, 3'd0, 5'd1, 1'b1);
      tick(); in_valid = 1'b0;
      n_cmp++; if (out_result !== 32'h84 || out_wen !== 1'b1) begin
         n_err++; $display("FAIL jalr_link: got %h/%b want 84/1", out_result, out_wen);
      end
      n_cmp++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h206) begin
         n_err++; $display("FAIL jalr_target: got %b/%h want 1/206", redirect_valid, redirect_pc);
      end
      tick();
   endtask

   task automatic test_blt();
      out_ready = 1'b1;
      set_instr(32'h40, 32'hFFFF_FFFF, 32'd1, 32'h10, 4'd4, 1'b0, 1'b0, 2'd1, 3'b100, 5'd2, 1'b1);
      tick();
      n_cmp++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h50) begin
         n_err++; $display("FAIL blt_taken: got %b/%h want 1/50", redirect_valid, redirect_pc);
      end
      set_instr(32'h40, 32'hFFFF_FFFF, 32'd1, 32'h10, 4'd6, 1'b0, 1'b0, 2'd1, 3'b110, 5'd2, 1'b1);
      tick(); in_valid = 1'b0;
      n_cmp++; if (redirect_valid !== 1'b0 || out_valid !== 1'b1) begin
         n_err++; $display("FAIL bltu_not_taken: got rv=%b ov=%b want rv=0 ov=1", redirect_valid, out_valid);
      end
      tick();
   endtask

   task automatic test_flush_reset();
      out_ready = 1'b0;
      set_instr(32'h0, 32'd1, 32'd1, 32'd0, 4'd0, 1'b0, 1'b0, 2'd0, 3'd0, 5'd8, 1'b1);
      tick();
      flush = 1'b1;
      tick(); flush = 1'b0; in_valid = 1'b0;
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_full: got %b want 0", out_valid); end
      // Flush during an active redirect pulse: pulse survives its own cycle.
      out_ready = 1'b1;
      set_instr(32'h10, 32'd0, 32'd0, 32'h30, 4'd0, 1'b0, 1'b0, 2'd2, 3'd0, 5'd1, 1'b1);
      tick(); in_valid = 1'b0; flush = 1'b1; #1;
      n_cmp++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h40) begin
         n_err++; $display("FAIL flush_keeps_redirect: got %b/%h want 1/40", redirect_valid, redirect_pc);
      end
      tick(); flush = 1'b0;
      n_cmp++; if (redirect_valid !== 1'b0 || out_valid !== 1'b0) begin
         n_err++; $display("FAIL flush_clears: got rv=%b ov=%b want 0/0", redirect_valid, out_valid);
      end
      // Reset during a stall.
      out_ready = 1'b0;
      set_instr(32'h200, 32'd0, 32'd0, 32'h8, 4'd0, 1'b0, 1'b0, 2'd2, 3'd0, 5'd7, 1'b1);
      tick(); in_valid = 1'b0;
      n_cmp++; if (out_valid !== 1'b1 || redirect_valid !== 1'b1) begin
         n_err++; $display("FAIL stall_setup: got ov=%b rv=%b want 1/1", out_valid, redirect_valid);
      end
      rst_n = 1'b0; in_valid = 1'b1;
      tick();
      n_cmp++; if (out_valid !== 1'b0 || redirect_valid !== 1'b0 || out_wen !== 1'b0 ||
                   out_result !== 32'd0 || out_rd !== 5'd0 || redirect_pc !== 32'd0) begin
         n_err++; $display("FAIL reset_mid_stall: got ov=%b rv=%b w=%b r=%h rd=%0d pc=%h want all 0",
                           out_valid, redirect_valid, out_wen, out_result, out_rd, redirect_pc);
      end
      rst_n = 1'b1; in_valid = 1'b0;
   endtask

   // ---------------- randomized scenario against the model ----------------
   task automatic test_random();
      logic        m_full, m_rv, m_wen, m_rdy, m_acc, m_tk;
      logic [31:0] m_res, m_rpc, a, b, r;
      logic [4:0]  m_rd;
      // Start from a known empty stage.
      flush = 1'b1; in_valid = 1'b0; tick(); flush = 1'b0;
      m_full = 1'b0; m_rv = 1'b0; m_wen = 1'b0; m_res = '0; m_rpc = '0; m_rd = '0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         @(negedge clk);
         in_valid    = ($urandom_range(0, 3) != 0);
         out_ready   = ($urandom_range(0, 2) != 0);
         flush       = ($urandom_range(0, 15) == 0);
         in_pc       = {$urandom_range(0, 32'h3FFF), 2'b00};
         in_rs1      = ($urandom_range(0, 1) != 0) ? $urandom : $urandom_range(0, 3);
         in_rs2      = ($urandom_range(0, 1) != 0) ? $urandom : $urandom_range(0, 3);
         in_imm      = ($urandom_range(0, 1) != 0) ? $urandom : $urandom_range(0, 64);
         in_alu_op   = 4'($urandom_range(0, 15));
         in_src1_pc  = 1'($urandom_range(0, 1));
         in_src2_imm = 1'($urandom_range(0, 1));
         in_kind     = 2'($urandom_range(0, 3));
         in_funct3   = 3'($urandom_range(0, 7));
         in_rd       = 5'($urandom_range(0, 31));
         in_wen      = 1'($urandom_range(0, 1));
         #1;
         m_rdy = !m_full || out_ready;
         n_cmp++; if (in_ready !== m_rdy) begin n_err++; $display("FAIL rnd_in_ready[%0d]: got %b want %b", cyc, in_ready, m_rdy); end
         n_cmp++; if (out_valid !== m_full) begin n_err++; $display("FAIL rnd_out_valid[%0d]: got %b want %b", cyc, out_valid, m_full); end
         n_cmp++; if (redirect_valid !== m_rv) begin n_err++; $display("FAIL rnd_redirect_valid[%0d]: got %b want %b", cyc, redirect_valid, m_rv); end
         if (m_full) begin
            n_cmp++; if (out_result !== m_res || out_rd !== m_rd || out_wen !== m_wen) begin
               n_err++; $display("FAIL rnd_payload[%0d]: got %h/%0d/%b want %h/%0d/%b", cyc, out_result, out_rd, out_wen, m_res, m_rd, m_wen);
            end
         end
         if (m_rv) begin
            n_cmp++; if (redirect_pc !== m_rpc) begin n_err++; $display("FAIL rnd_redirect_pc[%0d]: got %h want %h", cyc, redirect_pc, m_rpc); end
         end
         // Predict the effect of the coming edge.
         a = in_src1_pc ? in_pc : in_rs1;
         b = in_src2_imm ? in_imm : in_rs2;
         r = m_alu(in_alu_op, a, b);
         m_acc = in_valid && m_rdy && !flush;
         m_tk  = (in_kind == 2'd2) || (in_kind == 2'd3) || ((in_kind == 2'd1) && m_cond(in_funct3, r));
         m_rv  = m_acc && m_tk;
         if (flush) begin
            m_full = 1'b0;
         end else if (m_acc) begin
            m_full = 1'b1;
            m_rd   = in_rd;
            m_wen  = (in_kind == 2'd1) ? 1'b0 : in_wen;
            m_res  = (in_kind >= 2'd2) ? in_pc + 32'd4 : r;
            if (in_kind == 2'd3) m_rpc = (in_rs1 + in_imm) & ~32'd1;
            else                 m_rpc = in_pc + in_imm;
         end else if (m_full && out_ready) begin
            m_full = 1'b0;
         end
      end
      @(negedge clk);
      in_valid = 1'b0; flush = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
      set_instr('0, '0, '0, '0, 4'd0, 1'b0, 1'b0, 2'd0, 3'd0, 5'd0, 1'b0);
      in_valid = 1'b0;
      test_reset();
      test_alu_add();
      test_backpressure();
      test_beq();
      test_jalr();
      test_blt();
      test_flush_reset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
